ecg_sample_deframer: RTL

- Upstream feeder for the ECG algorithm core.
- Takes the byte stream from the UART receiver (one-cycle strobe per byte) and reassembles 11-bit ECG samples from two-byte frames.
- Buffers the samples in a small FIFO and releases them at a fixed paced rate as `ecg_value`/`data_valid` for the algorithm core.
- Counts framing and sequence errors, and flags FIFO overflow.

---
 rtl/ecg_sample_deframer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ecg_sample_deframer.sv
// Reassembles 11-bit ECG samples from two-byte UART frames, buffers them and releases them at a paced rate.
// Optional: define ECG_SEQ_CHECK_EN to build the 3-bit frame sequence checker and seq_err_cnt.
module ecg_sample_deframer #(
  parameter int FIFO_DEPTH = 16,
  parameter int PACE_DIV   = 100000,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          clr_status,
  output logic [10:0]                   ecg_value,
  output logic                          data_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [ERR_CNT_W-1:0]          frame_err_cnt,
  output logic [ERR_CNT_W-1:0]          seq_err_cnt,
  output logic                          fsm_state
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;

  typedef enum logic {IDLE = 1'b0, HAVE_HI = 1'b1} state_t;

  state_t           state, state_next;
  logic [6:0]       hi7;
  logic             hi_load;
  logic             frame_err_inc;
  logic             assemble;
  logic             is_hi;
  logic [10:0]      sample_in;

  logic [10:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty;
  logic             push_ok, pop, drop;

  logic [CNT_W-1:0] pace_cnt;
  logic             terminal;

  assign fsm_state = state;
  assign is_hi     = rx_data[7];
  assign sample_in = {hi7, rx_data[3:0]};

  // Frame FSM only advances on received bytes; an unexpected byte type counts
  // as a framing error and the stream resyncs on the next H byte.
  always_comb begin
    state_next    = state;
    hi_load       = 1'b0;
    frame_err_inc = 1'b0;
    assemble      = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (is_hi) begin
            hi_load    = 1'b1;
            state_next = HAVE_HI;
          end else begin
            frame_err_inc = 1'b1;
          end
        end
        HAVE_HI: begin
          if (is_hi) begin
            frame_err_inc = 1'b1;
            hi_load       = 1'b1;
          end else begin
            assemble   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hi7   <= '0;
    end else begin
      state <= state_next;
      if (hi_load) hi7 <= rx_data[6:0];
    end
  end

  assign terminal = ce && (pace_cnt == CNT_W'(PACE_DIV - 1));
  assign full     = (fifo_level == LW'(FIFO_DEPTH));
  assign empty    = (fifo_level == '0);
  assign pop      = terminal && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = assemble && (!full || pop);
  assign drop     = assemble && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pace_cnt <= '0;
    end else if (ce) begin
      pace_cnt <= terminal ? '0 : pace_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ecg_value  <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        ecg_value <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Status clear takes priority over any same-cycle increment or overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow      <= 1'b0;
      frame_err_cnt <= '0;
    end else if (clr_status) begin
      overflow      <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (frame_err_inc && (frame_err_cnt != {ERR_CNT_W{1'b1}}))
        frame_err_cnt <= frame_err_cnt + 1'b1;
    end
  end

`ifdef ECG_SEQ_CHECK_EN
  logic [2:0] seq_expected;
  logic       seq_locked;
  logic [2:0] seq_rx;
  logic       seq_err_inc;

  assign seq_rx      = rx_data[6:4];
  assign seq_err_inc = assemble && seq_locked && (seq_rx != seq_expected);

  // Whether in sequence or not, the next expected value follows the received one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_expected <= '0;
      seq_locked   <= 1'b0;
    end else if (assemble) begin
      seq_locked   <= 1'b1;
      seq_expected <= seq_rx + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_err_cnt <= '0;
    end else if (clr_status) begin
      seq_err_cnt <= '0;
    end else if (seq_err_inc && (seq_err_cnt != {ERR_CNT_W{1'b1}})) begin
      seq_err_cnt <= seq_err_cnt + 1'b1;
    end
  end
`else
  logic unused_seq_bits;
  assign unused_seq_bits = ^rx_data[6:4];
  assign seq_err_cnt     = '0;
`endif

endmodule
